ads1675_serial_tx: RTL and testbench

- Synthesizable emulator of the ADS1675 LVDS-side serial output: produces sclk, drdy and dout from parallel samples.
- Used for hardware-in-the-loop and loopback testing of the collection_sys ADS1675 receivers when no converter is fitted.
- Samples enter through a valid/ready port into a one-entry buffer.
- Each conversion frame is FRAME_LEN sclk periods long, data is sent MSB-first, and the frame begins with a drdy pulse.

---
 rtl/ads1675_pkg.sv | 19 +
 rtl/ads1675_sclk_gen.sv | 36 +++
 rtl/ads1675_serial_tx.sv | 161 ++++++++++++++++
 tb/tb_ads1675_serial_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads1675_pkg.sv
// Shared types and constants for the ADS1675 serial output emulator.
package ads1675_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    localparam int unsigned ADS1675_DW       = 24;
    localparam int unsigned ADS1675_FRAME_2M = 48;
    localparam int unsigned ADS1675_FRAME_4M = 24;
    localparam int unsigned ADS1675_DRDY_LEN = 3;

    // Counter width that stays at least one bit for tiny ranges.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/ads1675_sclk_gen.sv
// Free-running serial clock divider: sclk = aclk / (2*HALF_DIV).
// rise_tick marks the aclk edge on which sclk goes high.
module ads1675_sclk_gen
    import ads1675_pkg::*;
#(
    parameter int unsigned HALF_DIV = 2
) (
    input  logic aclk,
    input  logic areset_n,
    output logic sclk,
    output logic rise_tick
);

    localparam int unsigned          DIV_W    = clog2_min1(HALF_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             toggle;

    assign toggle    = (div_cnt == DIV_LAST);
    assign rise_tick = toggle && !sclk;

    // Half-period counter; sclk flips at terminal count.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (toggle) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ads1675_serial_tx.sv
// ADS1675 LVDS-side serial output emulator: one-entry sample buffer,
// frame FSM and MSB-first shifter driving drdy/dout on sclk rising edges.
module ads1675_serial_tx
    import ads1675_pkg::*;
#(
    parameter int unsigned DW        = ADS1675_DW,
    parameter int unsigned FRAME_LEN = ADS1675_FRAME_2M,
    parameter int unsigned DRDY_LEN  = ADS1675_DRDY_LEN,
    parameter int unsigned HALF_DIV  = 2
) (
    input  logic          aclk,
    input  logic          areset_n,
    input  logic          en,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          sclk,
    output logic          drdy,
    output logic          dout,
    output logic          frame_start,
    output logic          underrun,
    output logic          busy
);

    localparam int unsigned      CNT_W    = clog2_min1(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_DRDY = CNT_W'(DRDY_LEN);

    logic rise_tick;

    state_t           state,       state_n;
    logic [CNT_W-1:0] bit_cnt,     bit_cnt_n;
    logic             buf_full,    buf_full_n;
    logic [DW-1:0]    buf_data,    buf_data_n;
    logic [DW-1:0]    last_sample, last_sample_n;
    logic [DW-1:0]    shreg,       shreg_n;
    logic             s_ready_n;
    logic             drdy_n;
    logic             dout_n;
    logic             frame_start_n;
    logic             underrun_n;
    logic             busy_n;

    logic             accept;
    logic             load;
    logic [DW-1:0]    tx_sample;
    logic [CNT_W-1:0] cnt_inc;

    assign accept = s_valid && s_ready;

    ads1675_sclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sclk_gen (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .sclk      (sclk),
        .rise_tick (rise_tick)
    );

    // State, buffer, shifter and output registers.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            buf_full    <= 1'b0;
            buf_data    <= '0;
            last_sample <= '0;
            shreg       <= '0;
            s_ready     <= 1'b0;
            drdy        <= 1'b0;
            dout        <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            buf_full    <= buf_full_n;
            buf_data    <= buf_data_n;
            last_sample <= last_sample_n;
            shreg       <= shreg_n;
            s_ready     <= s_ready_n;
            drdy        <= drdy_n;
            dout        <= dout_n;
            frame_start <= frame_start_n;
            underrun    <= underrun_n;
            busy        <= busy_n;
        end
    end

    // Next-state: buffer accept, frame sequencing on sclk rising ticks, frame load.
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        buf_full_n    = buf_full;
        buf_data_n    = buf_data;
        last_sample_n = last_sample;
        shreg_n       = shreg;
        drdy_n        = drdy;
        dout_n        = dout;
        frame_start_n = 1'b0;
        underrun_n    = 1'b0;
        load          = 1'b0;
        cnt_inc       = bit_cnt + CNT_W'(1);
        tx_sample     = buf_full ? buf_data : last_sample;

        if (accept) begin
            buf_full_n = 1'b1;
            buf_data_n = s_data;
        end

        if (rise_tick) begin
            case (state)
                IDLE: begin
                    drdy_n = 1'b0;
                    dout_n = 1'b0;
                    if (en) begin
                        load = 1'b1;
                    end
                end
                FRAME: begin
                    if (bit_cnt == CNT_LAST) begin
                        if (en) begin
                            load = 1'b1;
                        end else begin
                            state_n   = IDLE;
                            bit_cnt_n = '0;
                            drdy_n    = 1'b0;
                            dout_n    = 1'b0;
                        end
                    end else begin
                        bit_cnt_n = cnt_inc;
                        drdy_n    = (cnt_inc < CNT_DRDY);
                        dout_n    = shreg[DW-1];
                        shreg_n   = shreg << 1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        // A sample accepted on the load edge stays buffered for the next frame.
        if (load) begin
            state_n       = FRAME;
            bit_cnt_n     = '0;
            drdy_n        = 1'b1;
            dout_n        = tx_sample[DW-1];
            shreg_n       = tx_sample << 1;
            last_sample_n = tx_sample;
            frame_start_n = 1'b1;
            underrun_n    = !buf_full;
            buf_full_n    = accept;
        end

        s_ready_n = !buf_full_n;
        busy_n    = (state_n == FRAME);
    end

endmodule

// File: tb/tb_ads1675_serial_tx.sv
// Directed bench for ads1675_serial_tx with a falling-edge receiver model.
module tb_ads1675_serial_tx;

    localparam int unsigned DW        = 24;
    localparam int unsigned FL        = 48;
    localparam int unsigned DL        = 3;
    localparam int unsigned HD        = 2;
    localparam int unsigned FRAME_CYC = 2 * HD * FL;

    logic          aclk = 1'b0;
    logic          areset_n;
    logic          en;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          sclk;
    logic          drdy;
    logic          dout;
    logic          frame_start;
    logic          underrun;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    ads1675_serial_tx #(
        .DW        (DW),
        .FRAME_LEN (FL),
        .DRDY_LEN  (DL),
        .HALF_DIV  (HD)
    ) dut (
        .aclk        (aclk),
        .areset_n    (areset_n),
        .en          (en),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .sclk        (sclk),
        .drdy        (drdy),
        .dout        (dout),
        .frame_start (frame_start),
        .underrun    (underrun),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    // Receiver model: frame starts on drdy seen high at a falling edge, 24 bits MSB-first.
    logic [DW-1:0] rx_shift = '0;
    int            rx_bits = 0;
    logic          rx_drdy_q = 1'b0;
    int            tail_ones = 0;
    logic [DW-1:0] rx_q[$];

    always @(negedge sclk or negedge areset_n) begin
        if (!areset_n) begin
            rx_bits   = 0;
            rx_drdy_q = 1'b0;
        end else begin
            if (drdy && !rx_drdy_q) begin
                rx_shift = DW'(dout);
                rx_bits  = 1;
            end else if (rx_bits > 0 && rx_bits < int'(DW)) begin
                rx_shift = {rx_shift[DW-2:0], dout};
                rx_bits++;
                if (rx_bits == int'(DW)) rx_q.push_back(rx_shift);
            end else if (rx_bits >= int'(DW) && dout) begin
                tail_ones++;
            end
            rx_drdy_q = drdy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        int t;
        t = 0;
        while (!s_ready && t < 500) begin
            @(negedge aclk);
            t++;
        end
        check("push_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge aclk);
        s_valid = 1'b0;
    endtask

    task automatic wait_fs(input string tag, output int cyc, output bit rdy_seen);
        cyc      = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge aclk);
            cyc++;
            if (!frame_start && s_ready) rdy_seen = 1'b1;
        end while (!frame_start && cyc < 500);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd1);
    endtask

    task automatic wait_idle(input string tag, output int busy_cyc, output int drdy_cyc,
                             output int ur_cyc);
        busy_cyc = 0;
        drdy_cyc = 0;
        ur_cyc   = 0;
        while (busy && busy_cyc < 1000) begin
            busy_cyc++;
            drdy_cyc += int'(drdy);
            ur_cyc   += int'(underrun);
            @(negedge aclk);
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic count_sclk(input int n, output int toggles, output int active);
        logic prev;
        prev    = sclk;
        toggles = 0;
        active  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            if (sclk !== prev) toggles++;
            if (drdy || dout || busy) active++;
            prev = sclk;
        end
    endtask

    task automatic check_rx(input string tag, input logic [DW-1:0] exp);
        check({tag, "_rx"}, (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    initial begin
        int            c, b, d, u, tg, qh, bad;
        bit            rs;
        logic [DW-1:0] smp;
        logic [DW-1:0] exp_q[$];

        areset_n = 1'b0;
        en       = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;

        // Reset state and release.
        repeat (4) @(negedge aclk);
        check("reset_outputs", 32'({sclk, drdy, dout, s_ready, frame_start, underrun, busy}), 32'd0);
        areset_n = 1'b1;
        @(negedge aclk);
        check("ready_after_release", 32'(s_ready), 32'd1);
        count_sclk(8, tg, qh);
        check("idle_sclk_toggles", 32'(tg), 32'd4);
        check("idle_quiet", 32'(qh), 32'd0);

        // Basic frame.
        push(24'hA5F00F);
        check("basic_accept_ready", 32'(s_ready), 32'd0);
        en = 1'b1;
        wait_fs("basic", c, rs);
        check("basic_latency", 32'(c >= 1 && c <= int'(2 * HD)), 32'd1);
        check("basic_load_outputs", 32'({drdy, dout, busy, underrun, s_ready}), 32'b11101);
        en = 1'b0;
        wait_idle("basic", b, d, u);
        check("basic_frame_len", 32'(b), 32'(FRAME_CYC));
        check("basic_drdy_len", 32'(d), 32'(DL * 2 * HD));
        check("basic_no_underrun", 32'(u), 32'd0);
        check("basic_idle_lines", 32'({drdy, dout}), 32'd0);
        check_rx("basic", 24'hA5F00F);
        check("basic_tail_zero", 32'(tail_ones), 32'd0);

        // Underrun: retransmit last sample.
        push(24'h123456);
        en = 1'b1;
        wait_fs("ur1", c, rs);
        check("ur1_no_underrun", 32'(underrun), 32'd0);
        wait_fs("ur2", c, rs);
        check("ur2_period", 32'(c), 32'(FRAME_CYC));
        check("ur2_underrun", 32'(underrun), 32'd1);
        en = 1'b0;
        wait_idle("ur2", b, d, u);
        check("ur2_pulse_width", 32'(u), 32'd1);
        check_rx("ur_first", 24'h123456);
        check_rx("ur_repeat", 24'h123456);

        // Back-to-back frames.
        push(24'h000001);
        en = 1'b1;
        wait_fs("b2b1", c, rs);
        push(24'h800000);
        check("b2b_accept_ready", 32'(s_ready), 32'd0);
        wait_fs("b2b2", c, rs);
        check("b2b_gap", 32'(c), 32'(FRAME_CYC - 1));
        check("b2b_ready_held_low", 32'(rs), 32'd0);
        check("b2b_load_flags", 32'({underrun, s_ready, drdy}), 32'b011);
        en = 1'b0;
        wait_idle("b2b", b, d, u);
        check("b2b_frame_len", 32'(b), 32'(FRAME_CYC));
        check_rx("b2b_first", 24'h000001);
        check_rx("b2b_second", 24'h800000);
        check("b2b_tail_zero", 32'(tail_ones), 32'd0);

        // en dropped at bit_cnt=10: frame still completes.
        push(24'h3C3C3C);
        en = 1'b1;
        wait_fs("drop", c, rs);
        repeat (40) @(negedge aclk);
        en = 1'b0;
        wait_idle("drop", b, d, u);
        check("drop_remaining_len", 32'(b), 32'(FRAME_CYC - 40));
        count_sclk(8, tg, qh);
        check("drop_sclk_runs", 32'(tg), 32'd4);
        check("drop_quiet", 32'(qh), 32'd0);
        check_rx("drop", 24'h3C3C3C);
        en = 1'b1;
        wait_fs("rearm", c, rs);
        check("rearm_latency", 32'(c >= 1 && c <= int'(2 * HD)), 32'd1);
        check("rearm_underrun", 32'(underrun), 32'd1);

        // Asynchronous reset at bit_cnt=5 with a sample buffered.
        push(24'h5A5A5A);
        repeat (19) @(negedge aclk);
        check("pre_reset_state", 32'({busy, drdy, s_ready}), 32'b100);
        #2;
        areset_n = 1'b0;
        #1;
        check("reset_async_outputs", 32'({sclk, drdy, dout, s_ready, frame_start, underrun, busy}), 32'd0);
        en = 1'b0;
        repeat (3) @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        check("reset_ready_after_release", 32'(s_ready), 32'd1);
        en = 1'b1;
        wait_fs("post_reset", c, rs);
        check("post_reset_underrun", 32'(underrun), 32'd1);
        en = 1'b0;
        wait_idle("post_reset", b, d, u);
        check_rx("post_reset_zero", 24'h000000);

        // Loopback of random samples through the receiver model.
        rx_q.delete();
        for (int i = 0; i < 100; i++) begin
            smp = DW'($urandom);
            exp_q.push_back(smp);
            push(smp);
            if (i == 0) en = 1'b1;
        end
        wait_fs("loop_last", c, rs);
        en = 1'b0;
        wait_idle("loop", b, d, u);
        check("loop_rx_count", 32'(rx_q.size()), 32'd100);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        end
        check("loop_rx_data", 32'(bad), 32'd0);
        check("loop_tail_zero", 32'(tail_ones), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
